// File: rtl/xbus_router_pkg.sv
// Shared types, default region map and helpers for the xbus router.
package xbus_router_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned NSlavesDflt = 4;

    // Slave i occupies bits [32i+31:32i]; slave 0 is the rightmost word.
    localparam logic [NSlavesDflt*32-1:0] BaseDflt = {
        32'h00010000, 32'h10000000, 32'h80000000, 32'h00001000
    };
    localparam logic [NSlavesDflt*32-1:0] LimitDflt = {
        32'h00010004, 32'h10000008, 32'h80010000, 32'h00001100
    };

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/xbus_region_match.sv
// Combinational address decoder: one-hot hit vector, lowest region index wins on overlap.
module xbus_region_match
    import xbus_router_pkg::*;
#(
    parameter int unsigned NSLAVES = NSlavesDflt
) (
    input  logic [31:0]           addr,
    input  logic [NSLAVES*32-1:0] base,
    input  logic [NSLAVES*32-1:0] limit,
    output logic [NSLAVES-1:0]    hit,
    output logic                  hit_any
);

    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (!hit_any && (addr >= base[i*32 +: 32]) && (addr < limit[i*32 +: 32])) begin
                hit[i]  = 1'b1;
                hit_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbus_router.sv
// Registered xbus router: decodes the master address, holds a one-hot chip select for the
// transaction, muxes ready/rdata back, and answers unmapped or timed-out accesses with an error.
module xbus_router
    import xbus_router_pkg::*;
#(
    parameter int unsigned                NSLAVES = NSlavesDflt,
    parameter int unsigned                DATA_W  = 32,
    parameter logic [NSLAVES*32-1:0]      BASE    = BaseDflt,
    parameter logic [NSLAVES*32-1:0]      LIMIT   = LimitDflt,
    parameter int unsigned                TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          xbus_as,
    input  logic [31:0]                   xbus_addr,
    output logic                          xbus_ready,
    output logic                          xbus_err,
    output logic [DATA_W-1:0]             xbus_rdata,
    output logic [NSLAVES-1:0]            xbus_cs,
    input  logic [NSLAVES-1:0]            s_ready,
    input  logic [NSLAVES*DATA_W-1:0]     s_rdata,
    output logic [31:0]                   err_addr,
    output logic [7:0]                    err_cnt
);

    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [NSLAVES-1:0]  cs_q, cs_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [7:0]          tmo_q, tmo_d;

    logic [NSLAVES-1:0]  hit;
    logic                hit_any;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    xbus_region_match #(
        .NSLAVES (NSLAVES)
    ) u_match (
        .addr    (xbus_addr),
        .base    (BASE),
        .limit   (LIMIT),
        .hit     (hit),
        .hit_any (hit_any)
    );

    // The held chip select doubles as the slave selector, so no separate index is kept.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (cs_q[i]) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (xbus_as) begin
                    if (hit_any) begin
                        cs_d    = hit;
                        tmo_d   = '0;
                        state_d = StWait;
                    end else begin
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        err_addr_d = xbus_addr;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        state_d    = StResp;
                    end
                end
            end
            StWait: begin
                if (!xbus_as) begin
                    cs_d    = '0;
                    state_d = StIdle;
                end else if (sel_ready) begin
                    rdata_d = sel_rdata;
                    ready_d = 1'b1;
                    cs_d    = '0;
                    state_d = StResp;
                end else if (tmo_q == TmoLast) begin
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    err_addr_d = xbus_addr;
                    err_cnt_d  = sat_inc(err_cnt_q);
                    cs_d       = '0;
                    state_d    = StResp;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                cs_d    = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cs_q       <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign xbus_cs    = cs_q;
    assign xbus_ready = ready_q;
    assign xbus_err   = err_q;
    assign xbus_rdata = rdata_q;
    assign err_addr   = err_addr_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_xbus_router.sv
// Directed bench for xbus_router: a transaction-level model sets per-cycle expectations that a
// negedge process compares against the DUT, plus literal spot checks.
module tb_xbus_router;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         xbus_as;
    logic [31:0]  xbus_addr;
    logic         xbus_ready, xbus_err;
    logic [31:0]  xbus_rdata;
    logic [3:0]   xbus_cs;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic [31:0]  err_addr;
    logic [7:0]   err_cnt;

    // Second instance with regions 0 and 1 overlapping exactly.
    logic         as2;
    logic [31:0]  addr2;
    logic         ready2, err2;
    logic [31:0]  rdata2, err_addr2;
    logic [3:0]   cs2;
    logic [7:0]   err_cnt2;

    always #5 clk = ~clk;

    xbus_router #(
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xbus_as    (xbus_as),
        .xbus_addr  (xbus_addr),
        .xbus_ready (xbus_ready),
        .xbus_err   (xbus_err),
        .xbus_rdata (xbus_rdata),
        .xbus_cs    (xbus_cs),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .err_addr   (err_addr),
        .err_cnt    (err_cnt)
    );

    xbus_router #(
        .BASE  ({32'h00003000, 32'h00002800, 32'h00002000, 32'h00002000}),
        .LIMIT ({32'h00003100, 32'h00002900, 32'h00002010, 32'h00002010})
    ) dut_ovl (
        .clk        (clk),
        .rst        (rst),
        .xbus_as    (as2),
        .xbus_addr  (addr2),
        .xbus_ready (ready2),
        .xbus_err   (err2),
        .xbus_rdata (rdata2),
        .xbus_cs    (cs2),
        .s_ready    (4'b0000),
        .s_rdata    ('0),
        .err_addr   (err_addr2),
        .err_cnt    (err_cnt2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state and current expectations.
    logic [31:0] m_rdata, m_ea;
    logic [7:0]  m_cnt;
    logic [3:0]  e_cs;
    logic        e_rdy, e_err;
    logic [31:0] e_rdata, e_ea;
    logic [7:0]  e_cnt;
    bit          chk_on = 0;

    logic [31:0] mbase [4] = '{32'h00001000, 32'h80000000, 32'h10000000, 32'h00010000};
    logic [31:0] mlim  [4] = '{32'h00001100, 32'h80010000, 32'h10000008, 32'h00010004};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (a >= mbase[i] && a < mlim[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cs",       {28'd0, xbus_cs}, {28'd0, e_cs});
            chk("ready",    {31'd0, xbus_ready}, {31'd0, e_rdy});
            chk("err",      {31'd0, xbus_err}, {31'd0, e_err});
            chk("rdata",    xbus_rdata, e_rdata);
            chk("err_addr", err_addr, e_ea);
            chk("err_cnt",  {24'd0, err_cnt}, {24'd0, e_cnt});
        end
    end

    task automatic step(input logic [3:0] cs, input logic rdy, input logic er);
        @(posedge clk);
        #1;
        e_cs    = cs;
        e_rdy   = rdy;
        e_err   = er;
        e_rdata = m_rdata;
        e_ea    = m_ea;
        e_cnt   = m_cnt;
    endtask

    // r: WAIT cycle with slave ready, ab: WAIT cycle with as dropped, rs: WAIT cycle with reset
    // (all 1-based, 0 = never).
    task automatic txn(input logic [31:0] a, input int r, input int ab, input int rs,
                       input logic [31:0] d);
        int         t;
        logic [3:0] oh;
        bit         done;
        t         = decode(a);
        xbus_as   = 1'b1;
        xbus_addr = a;
        s_ready   = '0;
        s_rdata   = {4{~d}};
        if (t < 0) begin
            m_ea  = a;
            m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
            step(4'b0000, 1'b1, 1'b1);
        end else begin
            oh   = 4'(1 << t);
            step(oh, 1'b0, 1'b0);
            done = 0;
            for (int w = 1; !done; w++) begin
                if (w == rs) begin
                    rst     = 1'b1;
                    m_rdata = '0;
                    m_ea    = '0;
                    m_cnt   = '0;
                    step(4'b0000, 1'b0, 1'b0);
                    rst  = 1'b0;
                    done = 1;
                end else if (w == ab) begin
                    xbus_as = 1'b0;
                    step(4'b0000, 1'b0, 1'b0);
                    done = 1;
                end else if (w == r) begin
                    s_ready = 4'hF;
                    s_rdata[t*32 +: 32] = d;
                    m_rdata = d;
                    step(4'b0000, 1'b1, 1'b0);
                    done = 1;
                end else if (w == TO) begin
                    s_ready = ~oh;
                    m_ea    = a;
                    m_cnt   = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
                    step(4'b0000, 1'b1, 1'b1);
                    done = 1;
                end else begin
                    s_ready = ~oh;
                    step(oh, 1'b0, 1'b0);
                end
            end
        end
        xbus_as = 1'b0;
        s_ready = '0;
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        xbus_as   = 1'b0;
        xbus_addr = '0;
        s_ready   = '0;
        s_rdata   = '0;
        as2       = 1'b0;
        addr2     = '0;
        m_rdata   = '0;
        m_ea      = '0;
        m_cnt     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs",    {28'd0, xbus_cs}, 32'd0);
        chk("rst_ready", {31'd0, xbus_ready}, 32'd0);
        chk("rst_cnt",   {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        step(4'b0000, 1'b0, 1'b0);
        chk_on = 1;

        chk("dec_s1",   decode(32'h80000010), 32'd1);
        chk("dec_edge", decode(32'h00001100), 32'hFFFFFFFF);

        txn(32'h80000010, 3, 0, 0, 32'hDEADBEEF);
        chk("t1_rdata", xbus_rdata, 32'hDEADBEEF);
        txn(32'h00001010, 1, 0, 0, 32'h0BADF00D);
        txn(32'h000010FF, 2, 0, 0, 32'h12345678);
        chk("lo_rdata", xbus_rdata, 32'h12345678);

        txn(32'h00001100, 0, 0, 0, 32'h0);
        chk("t2_ea",  err_addr, 32'h00001100);
        chk("t2_cnt", {24'd0, err_cnt}, 32'd1);
        txn(32'h00000FFF, 0, 0, 0, 32'h0);
        txn(32'h00010003, 1, 0, 0, 32'hCAFE0003);
        txn(32'h00010004, 0, 0, 0, 32'h0);

        txn(32'h10000000, 0, 0, 0, 32'h0);
        chk("t3_ea",  err_addr, 32'h10000000);
        chk("t3_cnt", {24'd0, err_cnt}, 32'd4);
        txn(32'h10000004, TO, 0, 0, 32'hA5A5A5A5);
        chk("t4_rdata", xbus_rdata, 32'hA5A5A5A5);
        chk("t4_cnt",   {24'd0, err_cnt}, 32'd4);

        txn(32'h00010000, 0, 2, 0, 32'h0);
        txn(32'h80000020, 0, 0, 3, 32'h0);
        chk("t5_ea",  err_addr, 32'h0);
        chk("t5_cnt", {24'd0, err_cnt}, 32'd0);

        for (int k = 0; k < 260; k++) txn(32'h00000000, 0, 0, 0, 32'h0);
        chk("t6_sat", {24'd0, err_cnt}, 32'h000000FF);
        txn(32'h80000004, 1, 0, 0, 32'h55AA55AA);
        chk("t6_hold", {24'd0, err_cnt}, 32'h000000FF);

        for (int k = 0; k < 2; k++) begin
            as2   = 1'b1;
            addr2 = (k == 0) ? 32'h00002004 : 32'h0000200F;
            @(posedge clk);
            #1;
            chk("ovl_cs", {28'd0, cs2}, 32'd1);
            as2 = 1'b0;
            @(posedge clk);
            #1;
            chk("ovl_abort", {28'd0, cs2}, 32'd0);
        end

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xbus_router.md
Name: xbus_router

Overview:
- Parametrised, registered successor to the combinational xbus chip-select decoder. It sits between the single xbus master (core LSU) and NSLAVES slaves.
- Decodes the address against a configurable region table, holds the chip select for the whole transaction, and muxes read data and ready back to the master.
- Generates a bus-error response for unmapped addresses and for slaves that fail to respond within TIMEOUT cycles.
- Records the last faulting address and a saturating error count.

Parameters:
- NSLAVES, 4, number of slave ports.
- DATA_W, 32, read-data width per slave.
- BASE, {32'h00010000,32'h10000000,32'h80000000,32'h00001000}, packed NSLAVES*32 region base addresses (inclusive), slave i in bits [32i+31:32i].
- LIMIT, {32'h00010004,32'h10000008,32'h80010000,32'h00001100}, packed NSLAVES*32 region limits (exclusive).
- TIMEOUT, 16, maximum WAIT cycles before an error response; legal range 2..255.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- xbus_as, in, 1, master address strobe; held high until xbus_ready.
- xbus_addr, in, 32, master address; stable while xbus_as is high.
- xbus_ready, out, 1, one-cycle response strobe to the master.
- xbus_err, out, 1, qualifies xbus_ready: 1 = bus error.
- xbus_rdata, out, DATA_W, read data, valid with xbus_ready and xbus_err=0.
- xbus_cs, out, NSLAVES, registered one-hot chip selects.
- s_ready, in, NSLAVES, per-slave ready.
- s_rdata, in, NSLAVES*DATA_W, per-slave read data, packed like BASE.
- err_addr, out, 32, address of the most recent errored transaction.
- err_cnt, out, 8, saturating error counter.

Behaviour:
- Reset: synchronous, active-high, single clock clk. On any rising edge with rst=1 the state becomes IDLE and all outputs go to 0: xbus_cs, xbus_ready, xbus_err, xbus_rdata, err_addr, err_cnt. This applies mid-transaction too; no response is issued for the aborted transfer.
- Region hit: slave i hits when BASE_i <= addr < LIMIT_i, using unsigned 32-bit compares. If several regions overlap, the lowest index wins, so xbus_cs is always one-hot or zero.
- States: IDLE, WAIT, RESP.
- IDLE:
  - xbus_as=1 with a hit on slave i: latch index, set xbus_cs[i]=1 at the next edge, clear the timeout counter, go to WAIT. Chip-select latency is 1 cycle.
  - xbus_as=1 with no hit: go to RESP with xbus_ready=1, xbus_err=1. Capture err_addr <= xbus_addr and increment err_cnt. xbus_cs stays 0.
- WAIT:
  - xbus_cs held constant.
  - If s_ready[sel]=1: capture xbus_rdata <= s_rdata[sel], set xbus_ready=1, xbus_err=0, clear xbus_cs, go to RESP.
  - Else if counter == TIMEOUT-1: set xbus_ready=1, xbus_err=1, capture err_addr, increment err_cnt, clear xbus_cs, go to RESP.
  - Else: counter+1.
  - Same-cycle ready and timeout: ready wins, no error.
  - s_ready of unselected slaves is ignored.
  - xbus_as dropping to 0 in WAIT: abort. Clear xbus_cs, go to IDLE, no xbus_ready pulse.
- RESP: xbus_ready/xbus_err are high for exactly this one cycle, then clear. xbus_as is ignored in RESP. Next state is IDLE. Minimum transaction spacing is therefore IDLE→…→RESP→IDLE.
- Latency: a slave ready in the first WAIT cycle gives xbus_ready 2 cycles after xbus_as is sampled.
- err_cnt saturates at 8'hFF and does not wrap.
- xbus_rdata holds its last value outside RESP.
- err_addr holds until the next error or reset.

Decomposition:
- config.vh: `NSLAVES, the default BASE/LIMIT words for each slave, and the state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- Sub-module xbus_region_match: combinational. Takes addr, BASE and LIMIT, returns a one-hot hit vector plus a hit_any flag, using a priority encode. It is instantiated once; the FSM and muxes live in xbus_router.

Test Plan:
1. Addr 0x80000010, s_ready[1] asserted in the 3rd WAIT cycle with rdata 0xDEADBEEF → xbus_cs=4'b0010 from cycle+1. xbus_ready=1, err=0, rdata=0xDEADBEEF at cycle+4. cs=0 in RESP.
2. Addr 0x00001100 (limit edge, unmapped) → xbus_cs stays 0. ready=1, err=1 next cycle. err_addr=0x00001100, err_cnt=1.
3. Addr 0x10000000 with s_ready never asserted, TIMEOUT=16 → cs[2] high for 16 cycles, then ready=1, err=1, err_cnt increments.
4. s_ready[sel] rises in exactly the TIMEOUT-1 WAIT cycle → ready=1, err=0, no err_cnt change.
5. xbus_as dropped in 2nd WAIT cycle → cs cleared next edge, no ready pulse. Also rst asserted in WAIT → all outputs 0 next edge.
6. 260 unmapped accesses to 0x00000000 → err_cnt saturates at 0xFF. Overlap test with BASE_0=BASE_1 → only cs[0] asserted.
